// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared SPI types and constants (master and slave)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_NRX_W  = 10;

    // Clock polarity/phase selection used by the master side.
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STORE = 2'd3
    } spi_slv_state_e;

endpackage

`default_nettype wire

// File: rtl/module_sync_edge.sv
// ============================================================================
// module_sync_edge : pin synchronizer with registered rise/fall pulses
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module module_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // prev_q trails the synchronized level so edges come out one cycle later.
    always_comb begin
        chain_d = SYNC_STAGES'({chain_q, d_i});
        prev_d  = chain_q[SYNC_STAGES-1];
        rise_d  = chain_q[SYNC_STAGES-1] & ~prev_q;
        fall_d  = ~chain_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            chain_q <= {SYNC_STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = chain_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/module_spi_slave.sv
// ============================================================================
// module_spi_slave : SPI mode-0 slave, oversampled by clk_i, with TX holding reg
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module module_spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sclk_i,
    input  logic                 cs_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    input  logic [DATA_W-1:0]    tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DATA_W-1:0]    rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 busy_o,
    output logic                 overrun_o,
    output logic [SPI_NRX_W-1:0] n_rx_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic unused_sync;

    module_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
        .level_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    module_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_i),
        .level_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    assign unused_sync = sclk_sync ^ cs_sync;

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_sync;

    spi_slv_state_e        state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]     tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  miso_q, miso_d;
    logic [DATA_W-1:0]     rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;
    logic [SPI_NRX_W-1:0]  n_rx_q, n_rx_d;
    logic [DATA_W-1:0]     next_byte;
    logic                  load_en, store_en, rise_en, fall_en, miso_clr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cs_fall) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_SHIFT;
                ST_SHIFT: if (sclk_rise && bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_STORE;
                ST_STORE: state_d = ST_SHIFT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / strobes ----------------
    // A CS rise blocks shifting and loading so an aborted byte leaves no trace.
    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        load_en  = (state_q == ST_LOAD) && !cs_rise;
        store_en = (state_q == ST_STORE);
        rise_en  = (state_q == ST_SHIFT) && sclk_rise && !cs_rise;
        fall_en  = (state_q == ST_SHIFT) && sclk_fall && !cs_rise;
        miso_clr = (state_q == ST_IDLE) || cs_rise;
    end

    // ---------------- datapath ----------------
    always_comb begin
        mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi_i});
        next_byte   = hold_full_q ? hold_q : '0;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        n_rx_d      = n_rx_q;

        // Consume before write: a write into an empty register on a consume
        // cycle lands in the holding register while the shifter gets zeros.
        if (load_en || store_en) hold_full_d = 1'b0;
        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        if (load_en) begin
            bit_cnt_d  = '0;
            n_rx_d     = '0;
            overrun_d  = 1'b0;
            miso_d     = next_byte[DATA_W-1];
            tx_shift_d = next_byte << 1;
        end
        if (rise_en) begin
            rx_shift_d = DATA_W'({rx_shift_q, mosi_sync});
            bit_cnt_d  = bit_cnt_q + 1'b1;
        end
        if (fall_en) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = tx_shift_q << 1;
        end

        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
        if (store_en) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            n_rx_d     = n_rx_q + 1'b1;
            bit_cnt_d  = '0;
            tx_shift_d = next_byte;
            if (rx_valid_q && !rx_ready_i) overrun_d = 1'b1;
        end

        if (miso_clr) miso_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mosi_sync_q <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            n_rx_q      <= '0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            n_rx_q      <= n_rx_d;
        end
    end

    assign mosi_sync  = mosi_sync_q[SYNC_STAGES-1];
    assign miso_o     = miso_q;
    assign tx_ready_o = ~hold_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign overrun_o  = overrun_q;
    assign n_rx_o     = n_rx_q;

endmodule

`default_nettype wire

// File: tb/tb_module_spi_slave.sv
// ============================================================================
// tb_module_spi_slave : scoreboard bench driving an SPI mode-0 master model
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_module_spi_slave;

    localparam int HALF = 8;

    logic       clk_i;
    logic       rst_i;
    logic       sclk_i;
    logic       cs_i;
    logic       mosi_i;
    logic       miso_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       busy_o;
    logic       overrun_o;
    logic [9:0] n_rx_o;

    int         checks;
    int         failures;
    bit         mon_en;
    logic [7:0] tx_feed[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    module_spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .cs_i(cs_i),
        .mosi_i(mosi_i), .miso_o(miso_o), .tx_data_i(tx_data_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .busy_o(busy_o), .overrun_o(overrun_o),
        .n_rx_o(n_rx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // TX feeder: tx_ready_o only changes on posedge, so a byte offered at
    // negedge while ready is accepted on the following posedge.
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = '0;
        forever begin
            @(negedge clk_i);
            tx_valid_i = 1'b0;
            if (tx_feed.size() != 0 && tx_ready_o && rst_i) begin
                tx_valid_i = 1'b1;
                tx_data_i  = tx_feed.pop_front();
            end
        end
    end

    // RX scoreboard: each accepted rx byte must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_en && rx_valid_o && rx_ready_i) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
                else                    chk("rx_data", rx_data_o, exp_rx.pop_front());
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic cs_low();
        cs_i = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        wait_clk(4);
        cs_i = 1'b1;
        wait_clk(8);
    endtask

    // Master transfer of nbits, MSB first; a full byte is checked against exp_miso.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit want_rx);
        logic [7:0] mi;
        mi = '0;
        if (want_rx) exp_rx.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
            mosi_i = mo[7-i];
            wait_clk(HALF);
            sclk_i = 1'b1;
            mi     = {mi[6:0], miso_o};
            wait_clk(HALF);
            sclk_i = 1'b0;
        end
        if (nbits == 8) begin
            if (exp_miso.size() == 0) chk("miso_unexpected", 32'd1, 32'd0);
            else                      chk("miso_byte", mi, exp_miso.pop_front());
        end
    endtask

    task automatic drain_rx();
        rx_ready_i = 1'b1;
        wait_clk(1);
        rx_ready_i = 1'b0;
        wait_clk(1);
        chk("rx_drained", rx_valid_o, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        rst_i      = 1'b0;
        sclk_i     = 1'b0;
        cs_i       = 1'b1;
        mosi_i     = 1'b0;
        rx_ready_i = 1'b0;
        wait_clk(3);
        chk("rst_miso", miso_o, 1'b0);
        chk("rst_tx_ready", tx_ready_o, 1'b1);
        chk("rst_rx_data", rx_data_o, 8'h00);
        chk("rst_rx_valid", rx_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_n_rx", n_rx_o, 10'd0);
        rst_i = 1'b1;
        wait_clk(5);

        // Single byte: slave returns preloaded 0xA5, master sends 0x3C.
        tx_feed.push_back(8'hA5);
        exp_miso.push_back(8'hA5);
        wait_clk(4);
        chk("t1_hold_full", tx_ready_o, 1'b0);
        cs_low();
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_hold_taken", tx_ready_o, 1'b1);
        xfer(8'h3C, 8, 1'b0);
        chk("t1_rx_data", rx_data_o, 8'h3C);
        chk("t1_rx_valid", rx_valid_o, 1'b1);
        chk("t1_n_rx", n_rx_o, 10'd1);
        cs_high();
        chk("t1_idle", busy_o, 1'b0);
        chk("t1_miso_idle", miso_o, 1'b0);
        drain_rx();

        // Three-byte frame with tx refilled on demand and rx always accepted.
        mon_en     = 1'b1;
        rx_ready_i = 1'b1;
        tx_feed.push_back(8'h11);
        tx_feed.push_back(8'h22);
        tx_feed.push_back(8'h33);
        exp_miso.push_back(8'h11);
        exp_miso.push_back(8'h22);
        exp_miso.push_back(8'h33);
        wait_clk(4);
        cs_low();
        xfer(8'hC1, 8, 1'b1);
        xfer(8'h7E, 8, 1'b1);
        xfer(8'h09, 8, 1'b1);
        wait_clk(2);
        chk("t2_n_rx", n_rx_o, 10'd3);
        chk("t2_overrun", overrun_o, 1'b0);
        cs_high();

        // Overrun with empty holding register: master reads zeros.
        mon_en     = 1'b0;
        rx_ready_i = 1'b0;
        exp_miso.push_back(8'h00);
        exp_miso.push_back(8'h00);
        cs_low();
        xfer(8'h81, 8, 1'b0);
        chk("t3_tx_ready", tx_ready_o, 1'b1);
        xfer(8'h42, 8, 1'b0);
        chk("t3_overrun", overrun_o, 1'b1);
        chk("t3_rx_data", rx_data_o, 8'h42);
        chk("t3_n_rx", n_rx_o, 10'd2);
        cs_high();
        chk("t3_overrun_sticky", overrun_o, 1'b1);
        cs_low();
        chk("t3_overrun_clr", overrun_o, 1'b0);
        cs_high();
        drain_rx();

        // Partial byte aborted by CS, then a clean frame.
        mon_en     = 1'b1;
        rx_ready_i = 1'b1;
        cs_low();
        xfer(8'hB4, 5, 1'b0);
        cs_high();
        chk("t4_busy", busy_o, 1'b0);
        chk("t4_rx_valid", rx_valid_o, 1'b0);
        chk("t4_n_rx", n_rx_o, 10'd0);
        tx_feed.push_back(8'h96);
        exp_miso.push_back(8'h96);
        wait_clk(4);
        cs_low();
        xfer(8'hE7, 8, 1'b1);
        wait_clk(2);
        chk("t4_n_rx_full", n_rx_o, 10'd1);
        cs_high();

        // Reset mid-byte after one completed byte, then a fresh 0x5A frame.
        tx_feed.push_back(8'h3A);
        exp_miso.push_back(8'h3A);
        wait_clk(4);
        cs_low();
        xfer(8'hF0, 8, 1'b1);
        xfer(8'hFF, 3, 1'b0);
        chk("t5_n_rx_pre", n_rx_o, 10'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("t5_rst_busy", busy_o, 1'b0);
        chk("t5_rst_rx_data", rx_data_o, 8'h00);
        chk("t5_rst_n_rx", n_rx_o, 10'd0);
        chk("t5_rst_tx_ready", tx_ready_o, 1'b1);
        chk("t5_rst_miso", miso_o, 1'b0);
        sclk_i = 1'b0;
        mosi_i = 1'b0;
        cs_i   = 1'b1;
        wait_clk(4);
        rst_i = 1'b1;
        wait_clk(10);
        chk("t5_post_busy", busy_o, 1'b0);
        tx_feed.push_back(8'hC3);
        exp_miso.push_back(8'hC3);
        wait_clk(4);
        cs_low();
        xfer(8'h5A, 8, 1'b1);
        wait_clk(2);
        chk("t5_n_rx", n_rx_o, 10'd1);
        cs_high();

        chk("rx_queue_empty", exp_rx.size(), 32'd0);
        chk("miso_queue_empty", exp_miso.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/module_spi_slave.md
MODULE_SPI_SLAVE -- requirements
Module: module_spi_slave

Interface
REQ-001 Parameter DATA_W, default 8: bits per SPI transfer (byte).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on the sclk_i, cs_i and mosi_i pins.
REQ-003 clk_i  in  1  system clock; the only clock; must run ≥8× SCLK frequency.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 sclk_i  in  1  SPI clock from master (CPOL=0, CPHA=0, mode b00).
REQ-006 cs_i  in  1  chip select from master, active-low.
REQ-007 mosi_i  in  1  serial data from master, MSB first.
REQ-008 miso_o  out  1  serial data to master, MSB first.
REQ-009 tx_data_i  in  DATA_W  next byte to transmit.
REQ-010 tx_valid_i  in  1  tx_data_i valid.
REQ-011 tx_ready_o  out  1  TX holding register empty.
REQ-012 rx_data_o  out  DATA_W  last received byte.
REQ-013 rx_valid_o  out  1  rx_data_o holds an unread byte.
REQ-014 rx_ready_i  in  1  consumer accepts rx_data_o.
REQ-015 busy_o  out  1  frame in progress (CS asserted).
REQ-016 overrun_o  out  1  sticky RX overrun flag.
REQ-017 n_rx_o  out  10  bytes completed in the current frame.

Function
REQ-018 sclk_i, cs_i and mosi_i SHALL pass SYNC_STAGES flops; sclk/cs rise and fall pulses SHALL be registered one cycle later (pin-to-event latency SYNC_STAGES+1 clk).
REQ-019 FSM states SHALL be IDLE, LOAD, SHIFT, STORE.
REQ-020 IDLE: busy_o=0, miso_o=0; a CS falling event SHALL move the FSM to LOAD.
REQ-021 LOAD (1 cycle): busy_o=1, bit_cnt=0, n_rx_o=0, overrun_o=0; miso_o <= next[MSB]; tx shifter <= next shifted left by one; then SHIFT.
REQ-022 "next" SHALL be the holding register when it is full (holding then empties); otherwise all zeros.
REQ-023 SHIFT, sclk rising event: rx shifter <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt += 1; if bit_cnt was DATA_W-1, go to STORE.
REQ-024 SHIFT, sclk falling event: miso_o <= tx_shift[MSB]; tx_shift <= tx_shift << 1.
REQ-025 STORE (1 cycle): rx_data_o <= assembled byte; rx_valid_o <= 1; n_rx_o += 1, wrapping 1023→0; bit_cnt=0; tx shifter <= next, unshifted, so the following falling edge presents its MSB; then SHIFT.
REQ-026 Overrun: when STORE occurs with rx_valid_o=1 and rx_ready_i=0, rx_data_o SHALL be overwritten and overrun_o set. overrun_o stays set until reset or the next LOAD.
REQ-027 rx_valid_o SHALL clear on the cycle after rx_valid_o & rx_ready_i, unless STORE occurs in the same cycle; in that case it stays 1 and no overrun is flagged.
REQ-028 tx_valid_i & tx_ready_o SHALL write the holding register; tx_ready_o = holding empty.
REQ-029 A same-cycle write and consume of an empty holding register SHALL give the shifter zeros and the holding register the new data.
REQ-030 A CS rising event in any state SHALL return the FSM to IDLE on the next cycle. A partial byte SHALL be discarded without an rx_valid_o pulse. The holding register is kept.
REQ-031 If a CS rise coincides with the final sclk rise of a byte, the CS rise SHALL win and the byte SHALL be discarded.

Reset
REQ-032 On rst_i low, asynchronously: state=IDLE, miso_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, overrun_o=0, n_rx_o=0, shifters=0, bit_cnt=0.
REQ-033 Synchronizer flops SHALL reset to the idle line levels: sclk 0, cs 1, mosi 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame. After release the block SHALL wait for a fresh CS falling edge.

Structure
REQ-035 The state enum, DATA_W default and the n_rx width constant (10) SHALL live in spi_pkg beside the master's types.
REQ-036 Synchronizer plus edge detect SHALL be one sub-module, module_sync_edge (outputs: sync level, rise, fall). It is instantiated for sclk and cs; mosi uses sync only.

Verification
REQ-037 Preload tx 0xA5, frame of 1 byte with master sending 0x3C: miso bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C; rx_valid_o=1; n_rx_o=1.
REQ-038 Frame of 3 bytes, tx 0x11, 0x22, 0x33 each written on tx_ready_o: master receives 0x11,0x22,0x33; n_rx_o=3; rx_ready_i held 1 gives no overrun.
REQ-039 Two bytes with rx_ready_i=0: overrun_o=1; rx_data_o=second byte; the next CS fall clears overrun_o.
REQ-040 CS rises after 5 SCLK rises: no rx_valid_o; FSM back in IDLE; busy_o=0; the next full frame receives correctly.
REQ-041 Empty holding register at CS fall: master receives 0x00; tx_ready_o stays 1.
REQ-042 rst_i pulsed low mid-byte: all outputs take their reset values immediately; a subsequent 0x5A frame is received correctly.
